// File: rtl/seq_alu_pkg.sv
// Shared definitions for the Sloth execute unit: op encodings, NZCV bit
// positions (also used by the downstream status register) and FSM states.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_mul_shift_add.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH cycles.
// done is high during the final iteration, with product showing that iteration's sum.
module mul_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_d;

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = (cnt_q == CW'(1));
    assign product = acc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mcand};
            mplier_q <= mplier;
            cnt_q    <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit producing a result plus NZCV flags and a status load strobe.
// Note: rst is active-low and asynchronous.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flag_en,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [3:0]       status_out,
    output logic             status_load
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         status_q, status_d;
    logic               flag_en_q, flag_en_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               dir_left_q, dir_left_d;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic               take;
    logic [WIDTH-1:0]   res_w;
    logic               c_w, v_w;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   shifted;
    logic               sh_out;

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   (a),
        .mplier  (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            status_q   <= '0;
            flag_en_q  <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            status_q   <= status_d;
            flag_en_q  <= flag_en_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            dir_left_q <= dir_left_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flag_en_d  = flag_en_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        dir_left_d = dir_left_q;
        mul_start  = 1'b0;
        take       = 1'b0;
        res_w      = '0;
        c_w        = 1'b0;
        v_w        = 1'b0;
        sum_w      = '0;
        shifted    = '0;
        sh_out     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    flag_en_d = flag_en;
                    case (op_e'(op))
                        OP_ADD: begin
                            sum_w   = {1'b0, a} + {1'b0, b};
                            res_w   = sum_w[WIDTH-1:0];
                            c_w     = sum_w[WIDTH];
                            v_w     = (a[WIDTH-1] == b[WIDTH-1]) && (res_w[WIDTH-1] != a[WIDTH-1]);
                            take    = 1'b1;
                            state_d = ST_DONE;
                        end
                        OP_SUB: begin
                            // Top bit of the widened difference is the borrow.
                            sum_w   = {1'b0, a} - {1'b0, b};
                            res_w   = sum_w[WIDTH-1:0];
                            c_w     = ~sum_w[WIDTH];
                            v_w     = (a[WIDTH-1] != b[WIDTH-1]) && (res_w[WIDTH-1] != a[WIDTH-1]);
                            take    = 1'b1;
                            state_d = ST_DONE;
                        end
                        OP_AND: begin
                            res_w   = a & b;
                            take    = 1'b1;
                            state_d = ST_DONE;
                        end
                        OP_OR: begin
                            res_w   = a | b;
                            take    = 1'b1;
                            state_d = ST_DONE;
                        end
                        OP_XOR: begin
                            res_w   = a ^ b;
                            take    = 1'b1;
                            state_d = ST_DONE;
                        end
                        OP_SHL, OP_SHR: begin
                            if (b[SHW-1:0] == '0) begin
                                res_w   = a;
                                take    = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                shreg_d    = a;
                                cnt_d      = b[SHW-1:0];
                                dir_left_d = (op_e'(op) == OP_SHL);
                                state_d    = ST_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            mul_start = 1'b1;
                            state_d   = ST_MUL;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (dir_left_q) begin
                    sh_out  = shreg_q[WIDTH-1];
                    shifted = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    sh_out  = shreg_q[0];
                    shifted = {1'b0, shreg_q[WIDTH-1:1]};
                end
                shreg_d = shifted;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    res_w   = shifted;
                    c_w     = sh_out;
                    take    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    res_w   = mul_product[WIDTH-1:0];
                    c_w     = |mul_product[2*WIDTH-1:WIDTH];
                    take    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        result_d = take ? res_w : result_q;
        status_d = take ? pack_flags(res_w[WIDTH-1], (res_w == '0), c_w, v_w) : status_q;
    end

    assign ready       = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign status_load = out_valid && flag_en_q;
    assign result      = result_q;
    assign status_out  = status_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle execute unit of the Sloth datapath, directly upstream of the 4-bit status register. It accepts one operation at a time through a start/ready handshake and produces a WIDTH-bit result. It also produces the NZCV flag nibble together with the one-cycle load strobe that the status register consumes. Single-cycle ops finish in one cycle; shifts and multiply iterate.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-low.
- start  in  1  request; accepted when start && ready at a rising edge.
- op  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for SHL/SHR only b[SHW-1:0] is used, as the shift amount.
- flag_en  in  1  when 1, the finished op updates status.
- ready  out  1  high only in IDLE.
- result  out  WIDTH  registered result, held until the next completion.
- out_valid  out  1  one-cycle completion pulse.
- status_out  out  4  {N,Z,C,V}; bit 3 = N, bit 0 = V; held like result.
- status_load  out  1  equals out_valid && captured flag_en; drives the status register load.

## Operation
- FSM states: IDLE, SHIFT, MUL, DONE.
- IDLE → DONE on accept of ADD/SUB/logic ops; the result is computed at the accept edge.
- IDLE → SHIFT on accept of SHL/SHR with shift amount > 0; shift amount 0 goes straight to DONE with result = a.
- IDLE → MUL on accept of MUL.
- SHIFT: shift one bit per cycle and decrement the counter; go to DONE when the counter reaches 0.
- MUL: shift-add over WIDTH iterations, with a 2·WIDTH-bit accumulator; go to DONE after the last iteration.
- DONE: out_valid = 1, status_load = flag_en_q; return to IDLE next cycle.
- op, a, b and flag_en are captured at accept. Input changes after accept have no effect.
- start while ready = 0 is ignored; there is no queueing.
- Flag rules:
  - N = result[WIDTH-1]; Z = (result == 0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = no-borrow (a ≥ b unsigned); V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - SHL/SHR: C = last bit shifted out (0 when shift amount is 0); V = 0.
  - MUL: result = low WIDTH bits of the product; C = (high WIDTH bits ≠ 0); V = 0.
- ADD/SUB arithmetic is modulo 2^WIDTH, computed through a WIDTH+1-bit sum for the carry.

## Timing
- Reset values: state IDLE, ready 1, result 0, status_out 0, out_valid 0, status_load 0, all counters 0.
- Reset is asynchronous: assertion clears every output and abandons any iteration in flight, with no completion pulse. The first accept is possible at the first rising edge after deassertion.
- Latency from the accept edge to the out_valid cycle:
  - ADD/SUB/logic: 1 cycle.
  - SHL/SHR: shift amount + 1 cycles.
  - MUL: WIDTH + 1 cycles.
- result and status_out change only in the cycle out_valid rises.
- ready drops in the cycle after accept and returns with the cycle after DONE. Throughput for single-cycle ops is one op every 2 cycles.
- Back-to-back: start held high re-accepts at the first edge where ready = 1.

## Structure
- Shared package holds:
  - the op encodings (OP_ADD … OP_MUL);
  - the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the FSM state encoding.
- The status register uses the same flag indices.
- One natural sub-module: mul_shift_add, the iterative multiplier (start, done, WIDTH-bit operands, 2·WIDTH-bit product). The shifter and single-cycle ops stay inline.

## Test plan
- Reset then idle → ready=1, result=0, status_out=0, out_valid and status_load never pulse.
- ADD a=0x7FFF, b=0x0001, flag_en=1 → one cycle later result=0x8000, status_out=4'b1001, out_valid and status_load pulse once together.
- SUB a=0x0005, b=0x0005 → result=0x0000, status_out=4'b0110. Then SUB a=0x0000, b=0x0001 → result=0xFFFF, status_out=4'b1000.
- SHL a=0x8001, b=0x0001 → out_valid 2 cycles after accept, result=0x0002, status_out=4'b0010. SHR a=0x00F0, b=0x0000 → latency 1, result=0x00F0, C=0.
- MUL a=0x0100, b=0x0100, flag_en=0 → out_valid exactly 17 cycles after accept, result=0x0000, status_out=4'b0110, status_load stays 0. Pulses of start during the op are ignored and ready stays low.
- Assert rst mid-MUL (cycle 8) → all outputs 0 immediately, ready=1. After release, ADD 3+4 → result=0x0007, status_out=4'b0000.
